vga_timing_gen: RTL



---
 rtl/vga_timing_pkg.sv | 41 ++++
 rtl/vga_delay_line.sv | 29 ++
 rtl/vga_timing_gen.sv | 128 ++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared types and mode constants for the VGA timing generator.
package vga_timing_pkg;

  localparam bit SYNC_NEG = 1'b0;
  localparam bit SYNC_POS = 1'b1;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
    bit hsync_pol;
    bit vsync_pol;
  } vga_mode_t;

  localparam vga_mode_t MODE_640X480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33,
    hsync_pol: SYNC_NEG, vsync_pol: SYNC_NEG
  };

  localparam vga_mode_t MODE_800X600_60 = '{
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
    hsync_pol: SYNC_POS, vsync_pol: SYNC_POS
  };

  // Per-pixel decode carried through the alignment pipeline.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic display_on;
    logic line;
    logic frame;
  } vga_sync_t;

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enabled shift register; DEPTH stages, all loading only when ce is high.
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // NOTE: every stage is reset, not just the output one -- otherwise stale
  // decode values would ripple out during the first DEPTH ticks after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
    end else if (ce) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, sync decode and a
// pix_ce-gated alignment pipeline for the sync and strobe outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = MODE_640X480_60.h_active,
  parameter int H_FP      = MODE_640X480_60.h_fp,
  parameter int H_SYNC    = MODE_640X480_60.h_sync,
  parameter int H_BP      = MODE_640X480_60.h_bp,
  parameter int V_ACTIVE  = MODE_640X480_60.v_active,
  parameter int V_FP      = MODE_640X480_60.v_fp,
  parameter int V_SYNC    = MODE_640X480_60.v_sync,
  parameter int V_BP      = MODE_640X480_60.v_bp,
  parameter bit HSYNC_POL = SYNC_NEG,
  parameter bit VSYNC_POL = SYNC_NEG,
  parameter int DELAY     = 0,
  parameter int FRAME_W   = 8,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_ce,
  output logic [HW-1:0]      hpos,
  output logic [VW-1:0]      vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1
      || DELAY < 0 || DELAY > 15) begin : g_bad_params
    $fatal(1, "vga_timing_gen: porch/sync widths must be >= 1 and DELAY in 0..15");
  end

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_ON  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_OFF = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_SYNC_ON  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_OFF = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam vga_sync_t SYNC_IDLE = '{
    hsync: ~HSYNC_POL, vsync: ~VSYNC_POL, display_on: 1'b0, line: 1'b0, frame: 1'b0
  };

  logic [HW-1:0]      hpos_q, hpos_d;
  logic [VW-1:0]      vpos_q, vpos_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               ce_q;
  vga_sync_t          sync_d, sync_q;

  // NOTE: defaults first so every path assigns every variable -- no latches.
  always_comb begin
    hpos_d  = hpos_q;
    vpos_d  = vpos_q;
    frame_d = frame_q;
    if (pix_ce) begin
      if (hpos_q == H_LAST) begin
        hpos_d = '0;
        if (vpos_q == V_LAST) begin
          vpos_d  = '0;
          frame_d = frame_q + 1'b1;
        end else begin
          vpos_d = vpos_q + 1'b1;
        end
      end else begin
        hpos_d = hpos_q + 1'b1;
      end
    end
  end

  always_comb begin
    sync_d = SYNC_IDLE;
    if (hpos_q >= H_SYNC_ON && hpos_q <= H_SYNC_OFF) sync_d.hsync = HSYNC_POL;
    if (vpos_q >= V_SYNC_ON && vpos_q <= V_SYNC_OFF) sync_d.vsync = VSYNC_POL;
    sync_d.display_on = (hpos_q < H_ACT_END) && (vpos_q < V_ACT_END);
    sync_d.line       = (hpos_q == '0);
    sync_d.frame      = (hpos_q == '0) && (vpos_q == '0);
  end

  // NOTE: non-blocking assignments keep all registers updating as one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hpos_q  <= '0;
      vpos_q  <= '0;
      frame_q <= '0;
      ce_q    <= 1'b0;
    end else begin
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      frame_q <= frame_d;
      ce_q    <= pix_ce;
    end
  end

  vga_delay_line #(
    .WIDTH   ($bits(vga_sync_t)),
    .DEPTH   (DELAY + 1),
    .RST_VAL (SYNC_IDLE)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .ce  (pix_ce),
    .d_i (sync_d),
    .q_o (sync_q)
  );

  // The last stage holds its flags across gated cycles; qualifying with the
  // registered tick limits each strobe to the cycle right after the load.
  assign line_start  = sync_q.line  & ce_q;
  assign frame_start = sync_q.frame & ce_q;

  assign hpos       = hpos_q;
  assign vpos       = vpos_q;
  assign frame_cnt  = frame_q;
  assign hsync      = sync_q.hsync;
  assign vsync      = sync_q.vsync;
  assign display_on = sync_q.display_on;

endmodule
